// File: rtl/pipe_ctrl.sv
// Hazard and sequencing controller for the 5-stage integer pipeline.
// Tracks EX/MEM/WB destinations and drives forwarding, load-use stall, redirect flush and freeze.
module pipe_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rstd,
    input  logic             id_valid,
    input  logic [5:0]       id_op,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic [4:0]       id_rd,
    input  logic             ex_redirect,
    input  logic             mem_ready,
    output logic             stall_if,
    output logic             stall_id,
    output logic             bubble_ex,
    output logic             flush_if,
    output logic             flush_id,
    output logic             freeze,
    output logic [1:0]       fwd_s,
    output logic [1:0]       fwd_t,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef struct packed {
        logic       valid;
        logic       wen;
        logic [4:0] wreg;
        logic       is_load;
    } shadow_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    shadow_t ex_q, mem_q, wb_q;

    logic       dec_def;
    logic [4:0] dec_wreg;
    logic       dec_wen;
    logic       dec_load;
    logic       uses_rs;
    logic       uses_rt;
    logic       load_use;
    logic       redirect;
    logic       active;

    always_comb begin
        dec_def  = 1'b0;
        dec_wreg = 5'd0;
        dec_load = 1'b0;
        uses_rs  = 1'b0;
        uses_rt  = 1'b0;
        if (id_valid) begin
            case (id_op)
                6'd0: begin
                    dec_def  = 1'b1;
                    dec_wreg = id_rd;
                    uses_rs  = 1'b1;
                    uses_rt  = 1'b1;
                end
                6'd1, 6'd4, 6'd5, 6'd6: begin
                    dec_def  = 1'b1;
                    dec_wreg = id_rt;
                    uses_rs  = 1'b1;
                end
                6'd3: begin
                    dec_def  = 1'b1;
                    dec_wreg = id_rt;
                end
                6'd16, 6'd18, 6'd20: begin
                    dec_def  = 1'b1;
                    dec_wreg = id_rt;
                    dec_load = 1'b1;
                    uses_rs  = 1'b1;
                end
                6'd24, 6'd26, 6'd28, 6'd32, 6'd33, 6'd34, 6'd35: begin
                    uses_rs = 1'b1;
                    uses_rt = 1'b1;
                end
                6'd41: begin
                    dec_def  = 1'b1;
                    dec_wreg = 5'd31;
                end
                6'd42: uses_rs = 1'b1;
                default: ;
            endcase
        end
    end

    assign dec_wen = dec_def & (dec_wreg != 5'd0);

    // Register 0 is hardwired, so it never matches a producer.
    function automatic logic hit(input shadow_t e, input logic [4:0] r);
        return e.valid & e.wen & (e.wreg == r) & (r != 5'd0);
    endfunction

    function automatic logic [1:0] fwd_sel(input logic used, input logic [4:0] r,
                                           input shadow_t ex, input shadow_t mem,
                                           input shadow_t wb);
        if (!used)         return 2'd0;
        else if (hit(ex, r))  return 2'd1;
        else if (hit(mem, r)) return 2'd2;
        else if (hit(wb, r))  return 2'd3;
        else                  return 2'd0;
    endfunction

    assign fwd_s = fwd_sel(uses_rs, id_rs, ex_q, mem_q, wb_q);
    assign fwd_t = fwd_sel(uses_rt, id_rt, ex_q, mem_q, wb_q);

    assign load_use = ex_q.is_load &
                      ((uses_rs & hit(ex_q, id_rs)) | (uses_rt & hit(ex_q, id_rt)));
    assign redirect = ex_redirect & ex_q.valid;
    assign active   = mem_ready;

    // Redirect wins over load-use; a frozen pipeline suppresses both.
    assign freeze    = ~mem_ready;
    assign flush_if  = active & redirect;
    assign flush_id  = active & redirect;
    assign stall_if  = active & load_use & ~redirect;
    assign stall_id  = active & load_use & ~redirect;
    assign bubble_ex = active & (redirect | load_use);

    always_ff @(posedge clk) begin
        if (!rstd) begin
            ex_q      <= '0;
            mem_q     <= '0;
            wb_q      <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (mem_ready) begin
            wb_q          <= mem_q;
            mem_q         <= ex_q;
            ex_q.valid    <= id_valid & ~bubble_ex;
            ex_q.wen      <= dec_wen;
            ex_q.wreg     <= dec_wreg;
            ex_q.is_load  <= dec_load;
            if (load_use && !redirect && stall_cnt != '1)
                stall_cnt <= stall_cnt + CNT_ONE;
            if (redirect && flush_cnt != '1)
                flush_cnt <= flush_cnt + CNT_ONE;
        end
    end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Hazard and sequencing controller for the 5-stage integer pipeline (IF, ID, EX, MEM, WB) built around the ALU. It keeps a shadow scoreboard of the destination register and write-enable of each instruction in EX, MEM and WB, and computes operand forwarding selects for the instruction leaving ID. It also generates the load-use stall, the branch/jump flush and the global freeze on data-memory wait, and it counts stall and flush cycles for performance monitoring.

## Interface
- CNT_W, 32, width of the saturating performance counters
- clk  in  1  clock, all state updates on rising edge
- rstd  in  1  reset, synchronous, active-low
- id_valid  in  1  ID stage holds a real instruction
- id_op  in  6  opcode of ID instruction
- id_rs, id_rt, id_rd  in  5 each  register fields of ID instruction
- ex_redirect  in  1  instruction in EX is a taken branch/jump; ignored unless the EX shadow entry is valid
- mem_ready  in  1  data memory completes this cycle; 0 freezes the whole pipeline
- stall_if  out  1  hold PC
- stall_id  out  1  hold IF/ID register
- bubble_ex  out  1  load a NOP into ID/EX
- flush_if, flush_id  out  1 each  kill instruction in IF / ID
- freeze  out  1  = ~mem_ready; hold every pipeline register
- fwd_s, fwd_t  out  2 each  operand source for os/ot latched into ID/EX: 0 regfile, 1 EX result, 2 MEM result (ALU or load data), 3 WB result
- stall_cnt, flush_cnt  out  CNT_W each  saturating event counters

## Operation
- ID decode, combinational:
  - wreg is rd for op 0; rt for ops 1,3,4,5,6,16,18,20; 31 for op 41; otherwise no write.
  - wen = wreg defined and wreg != 0.
  - is_load = op in {16,18,20}.
  - uses_rs = op in {0,1,4,5,6,16,18,20,24,26,28,32,33,34,35,42}.
  - uses_rt = op in {0,24,26,28,32,33,34,35}.
  - All decode terms are 0 when id_valid=0.
- Shadow entries EX, MEM, WB each hold {valid, wen, wreg, is_load}.
- Hit: stage entry is valid, has wen set, and its wreg equals the source field. Register 0 never hits.
- Forward select per source: EX hit → 1, else MEM hit → 2, else WB hit → 3, else 0. The youngest producer wins. The select is 0 when the source is unused.
- Load-use: a used source hits the EX entry and that entry has is_load set. In that case:
  - stall_if = stall_id = bubble_ex = 1.
  - fwd_s and fwd_t are don't-care.
- Redirect: ex_redirect is asserted and the EX entry is valid. In that case:
  - flush_if = flush_id = bubble_ex = 1.
  - Redirect overrides load-use; stall_if and stall_id are 0.
- Freeze: when mem_ready=0, freeze=1 and stall_if, stall_id, bubble_ex, flush_if and flush_id are all forced to 0. The shadow entries and counters hold.
- Counters:
  - stall_cnt increments on each cycle where mem_ready=1 and load-use is active without a redirect.
  - flush_cnt increments on each redirect cycle where mem_ready=1.
  - Both counters saturate at all-ones.

## Timing
- Outputs are combinational from the shadow state and the current inputs, with zero-cycle latency.
- The shadow shift happens on the rising edge only when rstd=1 and mem_ready=1:
  - WB ← MEM and MEM ← EX.
  - EX ← ID decode with valid = id_valid & ~bubble_ex.
- After a redirect edge, the killed ID instruction never enters EX, and the EX entry moves to MEM normally.
- After a load-use edge, EX holds a bubble and the load is in MEM. In the next cycle the same ID instruction is re-evaluated and gets fwd=2.
- Reset (rstd=0 at an edge) clears all valid bits and both counters to 0. The state after reset:
  - stall_if, stall_id, bubble_ex, flush_if, flush_id = 0.
  - fwd_s = fwd_t = 0.
  - freeze follows mem_ready.
- Reset mid-stall or mid-flush discards all in-flight tracking; there is no pending redirect after reset.
- Simultaneous events:
  - freeze overrides redirect; the redirect is still asserted after freeze releases because EX did not advance.
  - redirect overrides load-use.
  - Forward priority is EX > MEM > WB.

## Test plan
- Back-to-back ALU: op0 rd=5, then op0 rs=5 rt=5 → fwd_s=fwd_t=1, no stall. One cycle later, a third instruction with rs=5 → fwd_s=2. One more cycle → fwd_s=3.
- Load-use: op16 rt=7 in EX, op0 rs=7 in ID → stall_if=stall_id=bubble_ex=1 for exactly 1 cycle, stall_cnt=1. Next cycle fwd_s=2.
- Register 0 and op 3: op1 rt=0 followed by op0 rs=0 → fwd_s=0. op3 in ID after any producer → fwd_s=fwd_t=0.
- Redirect beats load-use: EX entry is a valid branch with ex_redirect=1 and a load-use hit is pending → flush_if=flush_id=bubble_ex=1, stall_if=0, flush_cnt=1, stall_cnt unchanged. The next EX entry is invalid.
- Freeze: mem_ready=0 for 3 cycles during a load-use → all control outputs 0 except freeze=1, shadow and counters unchanged. On release, the stall resumes.
- Reset and saturation: rstd=0 mid-redirect → next cycle all outputs 0 and counters 0. With CNT_W=4, 20 stall cycles → stall_cnt=15.
